sample_source_arbiter: RTL and testbench
========================================

SAMPLE_SOURCE_ARBITER -- requirements
Module: sample_source_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits, matching the modulator sample port.
REQ-002 Port clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port enable  input  1  arbitration enable.
REQ-005 Port mode  input  2  00 src0 only, 01 src1 only, 10 round-robin, 11 src0 fixed priority.
REQ-006 Port src0_sample  input  WIDTH  show-ahead head of source 0, valid while src0_empty=0.
REQ-007 Port src0_empty  input  1  source 0 has no data.
REQ-008 Port src0_read  output  1  pop strobe to source 0.
REQ-009 Ports src1_sample, src1_empty, src1_read: same as REQ-006..008 for source 1.
REQ-010 Port mod_sample  output  WIDTH  held sample presented to the modulator.
REQ-011 Port mod_empty  output  1  high when no sample is offered to the modulator.
REQ-012 Port mod_read  input  1  modulator pop strobe.
REQ-013 Port grant  output  1  source index of the held sample.
REQ-014 Port underrun_count  output  16  saturating count of starvation events.
REQ-015 Port cnt_clr  input  1  synchronous clear of underrun_count.

Function
REQ-016 Block SHALL contain a one-entry holding register (hold, valid) feeding mod_sample = hold.
REQ-017 mod_empty SHALL equal (~valid | ~enable), combinationally.
REQ-018 Eligible source: mode 00 -> src0; 01 -> src1; 10/11 -> both; a source is ready when eligible and its empty=0.
REQ-019 Fill condition: enable=1 and valid=0 and at least one ready source.
REQ-020 Selection: one ready -> that one; both ready, mode 11 -> src0; both ready, mode 10 -> ~last_grant.
REQ-021 srcN_read SHALL be combinational, high only in a fill cycle for the selected source; never both high.
REQ-022 In a fill cycle, at the clock edge: hold <= selected srcN_sample, valid <= 1, grant and last_grant <= selected index.
REQ-023 When valid=1, enable=1 and mod_read=1, valid SHALL clear at the edge; no refill in that same cycle (one-cycle bubble).
REQ-024 mod_read while mod_empty=1 SHALL be ignored.
REQ-025 enable=0: no fills, no pops; hold, valid and grant retained.
REQ-026 Mode changes SHALL affect only subsequent fills; the held sample is kept.
REQ-027 starved flag SHALL register (enable & ~valid & no ready source) each cycle.
REQ-028 underrun_count SHALL increment on each 0->1 transition of starved, saturating at 16'hFFFF.
REQ-029 cnt_clr=1 SHALL zero underrun_count; a coincident increment is discarded.
REQ-030 Latency: source data present in cycle N -> mod_empty=0 in cycle N+1.

Reset
REQ-031 rst=1 SHALL force hold=0, valid=0, grant=0, last_grant=1, starved=0, underrun_count=0.
REQ-032 During rst, src0_read, src1_read SHALL be 0 and mod_empty SHALL be 1.
REQ-033 Reset mid-operation SHALL discard the held sample without popping any source.
REQ-034 First round-robin grant after reset SHALL go to src0.

Verification
REQ-035 Mode 10, both sources non-empty (src0=8'h11, src1=8'h22), mod_read each time mod_empty=0 -> mod_sample sequence 11,22,11,22; grant 0,1,0,1.
REQ-036 Mode 11, both non-empty -> only src0_read pulses; src1 never popped while src0 non-empty.
REQ-037 Mode 00, src0 empty, src1 non-empty -> no srcN_read, mod_empty=1, underrun_count=1 after one starvation episode.
REQ-038 Sample held (8'h40), enable=0 for 10 cycles with mod_read=1 -> mod_empty=1, hold stays 8'h40; enable=1 -> pops once.
REQ-039 Force 65536 starvation episodes -> underrun_count holds 16'hFFFF; cnt_clr -> 0.
REQ-040 rst asserted with valid=1 -> next cycle mod_empty=1, no source read, next fill from src0 in mode 10.

Source files
------------

// File: rtl/sample_source_arbiter.sv
// rtl/sample_source_arbiter.sv - two-source sample arbiter with one-entry holding register
// Feeds a modulator from two show-ahead sources and counts starvation episodes.
module sample_source_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] src0_sample,
  input  logic             src0_empty,
  output logic             src0_read,
  input  logic [WIDTH-1:0] src1_sample,
  input  logic             src1_empty,
  output logic             src1_read,
  output logic [WIDTH-1:0] mod_sample,
  output logic             mod_empty,
  input  logic             mod_read,
  output logic             grant,
  output logic [15:0]      underrun_count,
  input  logic             cnt_clr
);

  localparam logic [1:0] MODE_SRC0 = 2'b00;
  localparam logic [1:0] MODE_SRC1 = 2'b01;
  localparam logic [1:0] MODE_PRIO = 2'b11;

  logic [WIDTH-1:0] hold;
  logic             valid;
  logic             grant_q;
  logic             last_grant;
  logic             starved;
  logic [15:0]      count;

  logic ready0, ready1, any_ready;
  logic fill, pop, sel, starved_d;

  always_comb begin
    ready0    = ((mode == MODE_SRC0) | mode[1]) & ~src0_empty;
    ready1    = ((mode == MODE_SRC1) | mode[1]) & ~src1_empty;
    any_ready = ready0 | ready1;
    fill      = ~rst & enable & ~valid & any_ready;
    pop       = ~rst & enable & valid & mod_read;
    // Contention only arises in the two-source modes; round-robin alternates.
    if (ready0 && ready1) begin
      sel = (mode == MODE_PRIO) ? 1'b0 : ~last_grant;
    end else begin
      sel = ready1;
    end
    starved_d = enable & ~valid & ~any_ready;
  end

  assign src0_read      = fill & ~sel;
  assign src1_read      = fill & sel;
  assign mod_sample     = hold;
  assign mod_empty      = rst | ~valid | ~enable;
  assign grant          = grant_q;
  assign underrun_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      valid      <= 1'b0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      starved    <= 1'b0;
      count      <= '0;
    end else begin
      if (fill) begin
        hold       <= sel ? src1_sample : src0_sample;
        valid      <= 1'b1;
        grant_q    <= sel;
        last_grant <= sel;
      end else if (pop) begin
        valid <= 1'b0;
      end
      starved <= starved_d;
      // Count rises of the starved flag; a clear wins over a same-cycle rise.
      if (cnt_clr) begin
        count <= '0;
      end else if (starved_d && !starved && count != 16'hFFFF) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sample_source_arbiter.sv
// tb/tb_sample_source_arbiter.sv - directed vector bench for sample_source_arbiter
module tb_sample_source_arbiter;

  logic        clk = 1'b0;
  logic        rst, enable, src0_empty, src1_empty, mod_read, cnt_clr;
  logic [1:0]  mode;
  logic [7:0]  src0_sample, src1_sample;
  logic        src0_read, src1_read, mod_empty, grant;
  logic [7:0]  mod_sample;
  logic [15:0] underrun_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sample_source_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .src0_sample(src0_sample), .src0_empty(src0_empty), .src0_read(src0_read),
    .src1_sample(src1_sample), .src1_empty(src1_empty), .src1_read(src1_read),
    .mod_sample(mod_sample), .mod_empty(mod_empty), .mod_read(mod_read),
    .grant(grant), .underrun_count(underrun_count), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic        rst, en;
    logic [1:0]  mode;
    logic [7:0]  s0;
    logic        e0;
    logic [7:0]  s1;
    logic        e1, rd, clr;
    logic        x_r0, x_r1, x_me;
    logic [7:0]  x_ms;
    logic        x_g;
    logic [15:0] x_uc;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [1:0] m, input logic [7:0] a,
                       input logic ea, input logic [7:0] b, input logic eb, input logic rd, input logic clr);
    rst = r; enable = en; mode = m; src0_sample = a; src0_empty = ea;
    src1_sample = b; src1_empty = eb; mod_read = rd; cnt_clr = clr;
  endtask

  initial begin
    //              rst en mode   s0    e0  s1    e1 rd clr  r0 r1 me ms    g  uc
    tbl[0]  = '{1'b1,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h00,1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,8'h00,1'b0,16'd0};
    tbl[2]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h11,1'b0,16'd0};
    tbl[3]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,8'h11,1'b0,16'd0};
    tbl[4]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h22,1'b1,16'd0};
    tbl[5]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,8'h22,1'b1,16'd0};
    tbl[6]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h11,1'b0,16'd0};
    tbl[7]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,8'h11,1'b0,16'd0};
    tbl[8]  = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h22,1'b1,16'd0};
    tbl[9]  = '{1'b0,1'b1,2'd3,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,8'h22,1'b1,16'd0};
    tbl[10] = '{1'b0,1'b1,2'd3,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h11,1'b0,16'd0};
    tbl[11] = '{1'b0,1'b1,2'd3,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,8'h11,1'b0,16'd0};
    tbl[12] = '{1'b0,1'b1,2'd3,8'h11,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h11,1'b0,16'd0};
    tbl[13] = '{1'b0,1'b1,2'd0,8'h11,1'b1,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h11,1'b0,16'd0};
    tbl[14] = '{1'b0,1'b1,2'd0,8'h11,1'b1,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h11,1'b0,16'd1};
    tbl[15] = '{1'b0,1'b1,2'd0,8'h11,1'b1,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h11,1'b0,16'd1};
    tbl[16] = '{1'b0,1'b1,2'd0,8'h40,1'b0,8'h22,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,8'h11,1'b0,16'd1};
    tbl[17] = '{1'b0,1'b0,2'd0,8'h40,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,8'h40,1'b0,16'd1};
    tbl[18] = '{1'b0,1'b1,2'd0,8'h40,1'b0,8'h22,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h40,1'b0,16'd1};
    tbl[19] = '{1'b0,1'b1,2'd0,8'h40,1'b1,8'h22,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h40,1'b0,16'd1};
    tbl[20] = '{1'b0,1'b1,2'd0,8'h40,1'b1,8'h22,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h40,1'b0,16'd2};
    tbl[21] = '{1'b0,1'b1,2'd0,8'h40,1'b1,8'h22,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h40,1'b0,16'd2};
    tbl[22] = '{1'b0,1'b1,2'd0,8'h40,1'b1,8'h22,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h40,1'b0,16'd0};
    tbl[23] = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,8'h40,1'b0,16'd0};
    tbl[24] = '{1'b1,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h22,1'b1,16'd0};
    tbl[25] = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,8'h00,1'b0,16'd0};
    tbl[26] = '{1'b0,1'b1,2'd2,8'h11,1'b0,8'h22,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h11,1'b0,16'd0};

    drive(1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].s0, tbl[i].e0,
            tbl[i].s1, tbl[i].e1, tbl[i].rd, tbl[i].clr);
      #1;
      check("src0_read", i, {15'd0, src0_read}, {15'd0, tbl[i].x_r0});
      check("src1_read", i, {15'd0, src1_read}, {15'd0, tbl[i].x_r1});
      check("mod_empty", i, {15'd0, mod_empty}, {15'd0, tbl[i].x_me});
      check("mod_sample", i, {8'd0, mod_sample}, {8'd0, tbl[i].x_ms});
      check("grant", i, {15'd0, grant}, {15'd0, tbl[i].x_g});
      check("underrun_count", i, underrun_count, tbl[i].x_uc);
    end

    // Held sample survives a disabled stretch with mod_read asserted, then pops once.
    @(negedge clk); drive(1'b1, 1'b0, 2'd0, 8'h40, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 2'd0, 8'h40, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    #1 check("hold_fill_read", 100, {15'd0, src0_read}, 16'd1);
    @(negedge clk); drive(1'b0, 1'b0, 2'd0, 8'h40, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("dis_mod_empty", 101 + k, {15'd0, mod_empty}, 16'd1);
      check("dis_hold", 101 + k, {8'd0, mod_sample}, 16'h0040);
      check("dis_no_read", 101 + k, {14'd0, src0_read, src1_read}, 16'd0);
      @(negedge clk);
    end
    enable = 1'b1;
    #1 check("en_mod_empty", 111, {15'd0, mod_empty}, 16'd0);
    @(negedge clk); mod_read = 1'b0;
    #1 check("popped_once", 112, {15'd0, mod_empty}, 16'd1);
    check("popped_hold", 112, {8'd0, mod_sample}, 16'h0040);

    // Saturation of the starvation counter, then a clear with a coincident rise.
    @(negedge clk); drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 65540; k++) begin
      @(negedge clk); rst = 1'b0; enable = 1'b1;
      @(negedge clk); enable = 1'b0;
      if (k == 0) begin
        #1 check("uc_first", 200, underrun_count, 16'd1);
      end
    end
    #1 check("uc_saturated", 201, underrun_count, 16'hFFFF);
    @(negedge clk); enable = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); enable = 1'b0; cnt_clr = 1'b0;
    #1 check("uc_cleared", 202, underrun_count, 16'd0);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    #1 check("uc_after_clear", 203, underrun_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
